// File: rtl/elegant_storage_reader.sv
// Burst read controller: wrapping read addresses, 2-entry output buffer.
// Optional STORAGE_READER_PARITY_EN adds out_parity stored per buffered word.
module elegant_storage_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
`ifdef STORAGE_READER_PARITY_EN
   output logic              out_parity,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W-1:0] remain;
   logic              inflight;
   logic              inflight_last;
   logic [1:0]        count;
   logic              wr_ptr, rd_ptr;
   logic [DATA_W-1:0] buf_data [2];
   logic              buf_last [2];
`ifdef STORAGE_READER_PARITY_EN
   logic              buf_par  [2];
`endif
   logic              pop, push, accept, final_rd;
   logic [2:0]        occ;

   assign pop       = out_valid & out_ready;
   assign push      = inflight;
   assign accept    = cmd_valid & cmd_ready;
   assign out_valid = (count != 2'd0);
   assign final_rd  = mem_rd_en & (remain == '0);

   // Slots that will be taken next cycle if nothing new is issued
   assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)            state_nxt = READ;
         READ:    if (final_rd)          state_nxt = DRAIN;
         DRAIN:   if (pop && out_last)   state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_rd_en   = 1'b0;
      busy        = 1'b0;
      mem_rd_addr = last_addr;
      unique case (state)
         IDLE:  busy = 1'b0;
         READ: begin
            busy      = 1'b1;
            mem_rd_en = (occ < 3'd2);
         end
         DRAIN: busy = 1'b1;
         default: busy = 1'b0;
      endcase
      if (mem_rd_en) mem_rd_addr = rd_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready     <= 1'b0;
         rd_addr       <= '0;
         last_addr     <= '0;
         remain        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         cmd_ready     <= (state_nxt == IDLE);
         inflight      <= mem_rd_en;
         inflight_last <= final_rd;
         if (accept) begin
            rd_addr <= cmd_addr;
            remain  <= cmd_len;
         end else if (mem_rd_en) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            last_addr <= rd_addr;
            remain    <= remain - ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_last[i] <= 1'b0;
`ifdef STORAGE_READER_PARITY_EN
            buf_par[i]  <= 1'b0;
`endif
         end
      end else begin
         count <= count + 2'(push) - 2'(pop);
         if (push) begin
            buf_data[wr_ptr] <= mem_rd_data;
            buf_last[wr_ptr] <= inflight_last;
`ifdef STORAGE_READER_PARITY_EN
            buf_par[wr_ptr]  <= ^mem_rd_data;
`endif
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
      end
   end

   assign out_data = buf_data[rd_ptr];
   assign out_last = out_valid & buf_last[rd_ptr];
`ifdef STORAGE_READER_PARITY_EN
   assign out_parity = out_valid & buf_par[rd_ptr];
`endif

endmodule

// File: doc/elegant_storage_reader.md
# elegant_storage_reader

Read-side controller for the 8-bit elegant storage bank. It accepts burst read commands through a valid/ready handshake and issues sequential, wrapping read addresses to the storage's synchronous read port. Returned words go into a 2-entry output buffer and are delivered on a valid/ready stream with an end-of-burst marker. It sits between the storage bank and any consumer that drains stored bytes.

## Interface
- DATA_W, 8, width of a storage word
- ADDR_W, 4, storage address width; the bank holds 2^ADDR_W words

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  a command is offered
- cmd_ready  out  1  block can accept a command (registered)
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W  burst length minus 1 (0 = 1 word, max = 2^ADDR_W words)
- mem_rd_en  out  1  storage read strobe
- mem_rd_addr  out  ADDR_W  storage read address
- mem_rd_data  in  DATA_W  storage data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_W  read word
- out_last  out  1  marks the final word of the burst
- busy  out  1  a command is in progress (state != IDLE)

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_addr and cmd_len, clear cmd_ready, go to READ.
  - READ: issue reads. After the read with remaining count 0 is issued, go to DRAIN.
  - DRAIN: wait until the word carrying out_last is popped, then go to IDLE and set cmd_ready on that edge.
- Issue rule: mem_rd_en=1 only in READ and only when (buffer occupancy + reads in flight − pop this cycle) < 2. The buffer must never overflow.
- Address sequence: each issued read increments the address modulo 2^ADDR_W, so addresses wrap (15→0 for ADDR_W=4).
- Each returned word is written to the buffer the cycle after its mem_rd_en. The word from the final issued read carries out_last=1.
- Output stream: out_data, out_last and parity (if enabled) hold stable while out_valid=1 and out_ready=0. A pop is out_valid&&out_ready.
- The buffer is FIFO-ordered; a push and a pop in the same cycle are both allowed.
- cmd_valid asserted while busy is ignored; nothing is latched.
- mem_rd_addr holds its last value when mem_rd_en=0.

## Timing
- Reset values (async, rst_n low): state IDLE, cmd_ready=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, buffer empty, in-flight count 0.
- cmd_ready goes to 1 at the first rising edge after rst_n deasserts.
- Latency: accept in cycle 0; mem_rd_en in cycle 1; data captured at the end of cycle 2; out_valid=1 in cycle 3.
- Throughput: with out_ready held at 1, one word per cycle. An N-word burst shows out_valid in cycles 3..N+2, and out_last in cycle N+2.
- Back-to-back commands: the cycle after the last pop, cmd_ready=1. The minimum gap between accepts is N+3 cycles.
- Reset mid-burst aborts immediately. Buffered and in-flight words are discarded, and mem_rd_data arriving after reset is ignored.
- Backpressure: while out_ready=0 with 2 words buffered, mem_rd_en stays 0. Issuing resumes in the cycle of the next pop.

## Configuration
- STORAGE_READER_PARITY_EN defined:
  - Adds output out_parity (1 bit), the even parity (XOR reduction) of the word, computed at buffer write and stored alongside it.
  - out_parity is 0 in reset and holds stable with out_data.
- Undefined: the out_parity port and its storage are absent. All other behaviour is identical.

## Test plan
- Single word: storage[3]=0x55; command addr=3, len=0, out_ready=1 → mem_rd_en in cycle 1 with addr 3; out_valid in cycle 3 with out_data=0x55, out_last=1; cmd_ready=1 in cycle 4.
- Wrap burst: storage[14..15,0..1]=0xAA,0xBB,0xCC,0xDD; command addr=14, len=3 → read addresses 14,15,0,1; outputs AA,BB,CC,DD in consecutive cycles 3–6; out_last only on DD.
- Backpressure: 4-word burst with out_ready=0 for 5 cycles after the first out_valid → data held at first word, at most 2 reads issued, no loss; then words in order.
- Busy ignore: cmd_valid held during a burst with a different addr → no second burst until cmd_ready=1; accepted exactly once after.
- Reset mid-burst: rst_n low in cycle 4 of a 16-word burst → all outputs 0 immediately; after release the new command addr=0, len=0 returns storage[0] correctly.
- Parity (macro on): storage word 0xFF → out_parity=0; word 0x07 → out_parity=1.
